// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// the mapping of log-shifter layers onto pipeline stages.
package shifter_pkg;

    localparam logic [2:0] MODE_SRA  = 3'b000;
    localparam logic [2:0] MODE_SRL  = 3'b001;
    localparam logic [2:0] MODE_SLL  = 3'b010;
    localparam logic [2:0] MODE_SLL2 = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;

    // Pipeline stage that holds layer k when SHW layers are spread over STAGES stages.
    function automatic int stage_of(input int k, input int stages, input int shw);
        return (k * stages) / shw;
    endfunction

endpackage

// File: rtl/shift_layer.sv
// One combinational layer of the log shifter: shifts or rotates by DIST when
// its shift-amount bit is set, and updates the candidate carry-out bit.
module shift_layer
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       mode_i,
    input  logic             fill_i,
    input  logic             sh_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] data_o,
    output logic             carry_o
);

    always_comb begin
        data_o  = data_i;
        carry_o = carry_i;
        if (sh_i) begin
            // The last bit leaving this layer is the carry candidate; later layers overwrite it.
            case (mode_i)
                MODE_SRA: begin
                    data_o  = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
                    carry_o = data_i[DIST-1];
                end
                MODE_SRL: begin
                    data_o  = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
                    carry_o = data_i[DIST-1];
                end
                MODE_ROR: begin
                    data_o  = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
                    carry_o = data_i[DIST-1];
                end
                MODE_SLL, MODE_SLL2: begin
                    data_o  = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
                    carry_o = data_i[WIDTH-DIST];
                end
                MODE_ROL: begin
                    data_o  = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
                    carry_o = data_i[WIDTH-DIST];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined log shifter with rotate modes, carry/zero flags and a
// valid/ready handshake; SHW layers are distributed over STAGES registers.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int   WIDTH  = 32,
    parameter int   STAGES = 2,
    localparam int  SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] dat_q [STAGES];
    logic [WIDTH-1:0] dat_d [STAGES];
    logic             cy_q  [STAGES];
    logic             cy_d  [STAGES];
    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [2:0]       mode_q[STAGES];
    logic [SHW-1:0]   b_q   [STAGES];
    logic             sign_q[STAGES];
    logic             zero_q;

    logic [WIDTH-1:0] src_dat [STAGES];
    logic             src_cy  [STAGES];
    logic [2:0]       src_mode[STAGES];
    logic [SHW-1:0]   src_b   [STAGES];
    logic             src_sign[STAGES];

    logic [WIDTH-1:0] lin_dat [SHW];
    logic [WIDTH-1:0] lout_dat[SHW];
    logic             lin_cy  [SHW];
    logic             lout_cy [SHW];

    logic [STAGES-1:0] unused_pipe;
    logic              en;

    // Single global advance: the whole pipe moves or the whole pipe holds.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign src_dat[s]  = a;
            assign src_cy[s]   = 1'b0;
            assign src_mode[s] = mode;
            assign src_b[s]    = b;
            assign src_sign[s] = a[WIDTH-1];
            assign vld_d[s]    = in_valid;
        end else begin : g_body
            assign src_dat[s]  = dat_q[s-1];
            assign src_cy[s]   = cy_q[s-1];
            assign src_mode[s] = mode_q[s-1];
            assign src_b[s]    = b_q[s-1];
            assign src_sign[s] = sign_q[s-1];
            assign vld_d[s]    = vld_q[s-1];
        end
        assign unused_pipe[s] = ^{mode_q[s], b_q[s], sign_q[s]};
    end

    for (genvar k = 0; k < SHW; k++) begin : g_layer
        localparam int S     = stage_of(k, STAGES, SHW);
        localparam bit FIRST = (k == 0) || (stage_of(k - 1, STAGES, SHW) != S);
        localparam bit LAST  = (k == SHW - 1) || (stage_of(k + 1, STAGES, SHW) != S);

        if (FIRST) begin : g_from_stage
            assign lin_dat[k] = src_dat[S];
            assign lin_cy[k]  = src_cy[S];
        end else begin : g_from_layer
            assign lin_dat[k] = lout_dat[k-1];
            assign lin_cy[k]  = lout_cy[k-1];
        end

        shift_layer #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_layer (
            .data_i  (lin_dat[k]),
            .mode_i  (src_mode[S]),
            .fill_i  (src_sign[S]),
            .sh_i    (src_b[S][k]),
            .carry_i (lin_cy[k]),
            .data_o  (lout_dat[k]),
            .carry_o (lout_cy[k])
        );

        if (LAST) begin : g_to_reg
            assign dat_d[S] = lout_dat[k];
            assign cy_d[S]  = lout_cy[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                dat_q[s]  <= '0;
                cy_q[s]   <= 1'b0;
                vld_q[s]  <= 1'b0;
                mode_q[s] <= '0;
                b_q[s]    <= '0;
                sign_q[s] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (en) begin
            for (int s = 0; s < STAGES; s++) begin
                dat_q[s]  <= dat_d[s];
                cy_q[s]   <= cy_d[s];
                vld_q[s]  <= vld_d[s];
                mode_q[s] <= src_mode[s];
                b_q[s]    <= src_b[s];
                sign_q[s] <= src_sign[s];
            end
            zero_q <= (dat_d[STAGES-1] == '0);
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign c         = dat_q[STAGES-1];
    assign carry     = cy_q[STAGES-1];
    assign zero      = zero_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe: 32-bit/2-stage instance for the main
// function and handshake, plus an 8-bit/3-stage instance for the rotate regression.
module tb_shifter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, carry, zero;
    logic [31:0] a, c;
    logic [4:0]  b;
    logic [2:0]  mode;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, carry8, zero8;
    logic [7:0]  a8, c8;
    logic [2:0]  b8;
    logic [2:0]  mode8;

    int n_vec = 0;
    int n_err = 0;
    int nvalid;

    shifter_pipe #(.WIDTH(32), .STAGES(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .carry(carry), .zero(zero)
    );

    shifter_pipe #(.WIDTH(8), .STAGES(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
        .c(c8), .carry(carry8), .zero(zero8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with an idle input; result expected one edge after acceptance.
    task automatic op32(input logic [31:0] av, input logic [4:0] bv, input logic [2:0] mv,
                        input logic [31:0] ec, input logic ecy, input string tag);
        a = av; b = bv; mode = mv; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".c"}, c, ec);
        chk({tag, ".carry"}, {31'd0, carry}, {31'd0, ecy});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, (ec == 32'd0)});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; mode = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; mode8 = '0;
        #2;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.c", c, 32'd0);
        chk("rst.carry", {31'd0, carry}, 32'd0);
        chk("rst.zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op32(32'hffff_0000, 5'd10, 3'b000, 32'hffff_ffc0, 1'b0, "b10.sra");
        op32(32'hffff_0000, 5'd10, 3'b001, 32'h003f_ffc0, 1'b0, "b10.srl");
        op32(32'hffff_0000, 5'd10, 3'b010, 32'hfc00_0000, 1'b1, "b10.sll");
        op32(32'hffff_0000, 5'd10, 3'b011, 32'hfc00_0000, 1'b1, "b10.sll2");
        op32(32'hffff_0000, 5'd10, 3'b100, 32'h003f_ffc0, 1'b0, "b10.ror");
        op32(32'hffff_0000, 5'd10, 3'b101, 32'hfc00_03ff, 1'b1, "b10.rol");
        op32(32'hffff_0000, 5'd16, 3'b000, 32'hffff_ffff, 1'b0, "b16.sra");
        op32(32'hffff_0000, 5'd16, 3'b001, 32'h0000_ffff, 1'b0, "b16.srl");
        op32(32'hffff_0000, 5'd16, 3'b010, 32'h0000_0000, 1'b1, "b16.sll");
        op32(32'hffff_0000, 5'd0,  3'b000, 32'hffff_0000, 1'b0, "b0.sra");
        op32(32'hffff_0000, 5'd0,  3'b100, 32'hffff_0000, 1'b0, "b0.ror");
        op32(32'hffff_0000, 5'd0,  3'b101, 32'hffff_0000, 1'b0, "b0.rol");
        op32(32'hffff_0000, 5'd31, 3'b000, 32'hffff_ffff, 1'b1, "b31.sra");
        op32(32'hffff_0000, 5'd31, 3'b001, 32'h0000_0001, 1'b1, "b31.srl");
        op32(32'h0000_0001, 5'd31, 3'b101, 32'h8000_0000, 1'b0, "b31.rol");
        op32(32'h0000_0001, 5'd1,  3'b100, 32'h8000_0000, 1'b1, "b1.ror");
        op32(32'h1234_5678, 5'd5,  3'b110, 32'h1234_5678, 1'b0, "pass110");
        op32(32'h1234_5678, 5'd5,  3'b111, 32'h1234_5678, 1'b0, "pass111");

        // Back-to-back stream: op j is 1<<j and must appear two falling edges after it is driven.
        nvalid = 0;
        for (int j = 0; j < 11; j++) begin
            if (j >= 1) begin
                chk("stream.valid", {31'd0, out_valid}, {31'd0, (j >= 2 && j <= 9)});
                if (j >= 2 && j <= 9) begin
                    nvalid++;
                    chk("stream.c", c, 32'h1 << (j - 2));
                end
            end
            if (j < 8) begin
                in_valid = 1'b1; a = 32'h1; b = 5'(j); mode = 3'b010;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream.count", nvalid, 32'd8);

        // Fill the pipe, then hold out_ready low for three edges.
        in_valid = 1'b1; a = 32'h0000_00f0; b = 5'd4; mode = 3'b001;
        @(negedge clk);
        a = 32'h0000_0001; b = 5'd31; mode = 3'b010;
        @(negedge clk);
        chk("stall.first", c, 32'h0000_000f);
        out_ready = 1'b0;
        a = 32'h8000_0000; b = 5'd4; mode = 3'b000;
        #1;
        chk("stall.in_ready0", {31'd0, in_ready}, 32'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall.valid", {31'd0, out_valid}, 32'd1);
            chk("stall.c_hold", c, 32'h0000_000f);
            chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall.op1", c, 32'h8000_0000);
        @(negedge clk);
        chk("stall.op2.valid", {31'd0, out_valid}, 32'd1);
        chk("stall.op2", c, 32'hf800_0000);
        @(negedge clk);
        chk("stall.drained", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with two operations in flight.
        in_valid = 1'b1; a = 32'hffff_0000; b = 5'd10; mode = 3'b001;
        @(negedge clk);
        a = 32'h1234_5678; b = 5'd4; mode = 3'b101;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst.c", c, 32'd0);
        chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("arst.no_stale", {31'd0, out_valid}, 32'd0);
        end
        op32(32'hffff_0000, 5'd10, 3'b101, 32'hfc00_03ff, 1'b1, "arst.next");

        // 8-bit, 3-stage instance: rotate left by one wraps the MSB into bit 0.
        in_valid8 = 1'b1; a8 = 8'h81; b8 = 3'd1; mode8 = 3'b101;
        @(negedge clk);
        in_valid8 = 1'b0;
        chk("w8.early1", {31'd0, out_valid8}, 32'd0);
        @(negedge clk);
        chk("w8.early2", {31'd0, out_valid8}, 32'd0);
        @(negedge clk);
        chk("w8.valid", {31'd0, out_valid8}, 32'd1);
        chk("w8.c", {24'd0, c8}, 32'h0000_0003);
        chk("w8.carry", {31'd0, carry8}, 32'd1);
        chk("w8.zero", {31'd0, zero8}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
